// File: rtl/anton_neopixel_buffered.sv
// Buffered WS2812-style frame transmitter: pixel buffer, prefetching bit serializer
// and latch timer, with optional back-to-back frame looping.
module anton_neopixel_buffered #(
  parameter int unsigned PIXELS          = 8,
  parameter int unsigned BYTES_PER_PIXEL = 3,
  parameter int unsigned BIT_TICKS       = 12,
  parameter int unsigned T0H_TICKS       = 3,
  parameter int unsigned T1H_TICKS       = 8,
  parameter int unsigned RESET_TICKS     = 500,
  localparam int unsigned AW = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int unsigned DW = 8 * BYTES_PER_PIXEL
) (
  input  logic          CLK_10MHZ,
  input  logic          RESET,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [DW-1:0] WR_DATA,
  input  logic          START,
  input  logic          LOOP,
  output logic          BUSY,
  output logic          DONE,
  output logic          NEO_DATA,
  output logic [1:0]    VERBOSE_STATE
);

  localparam int unsigned TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int unsigned BW = $clog2(DW);
  localparam int unsigned RW = (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_BIT   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [PIXELS];
  logic [DW-1:0] shift;
  logic [DW-1:0] pre;
  logic [TW-1:0] tick;
  logic [BW-1:0] bitn;
  logic [AW-1:0] pix;
  logic [RW-1:0] lat;

  logic          tick_last;
  logic          bit_last;
  logic          pix_last;
  logic          nxt_bit;
  logic [TW-1:0] nxt_tick;
  logic          neo_nxt;

  assign VERBOSE_STATE = state;

  // Pixel buffer; out-of-range addresses and writes under reset are dropped.
  always_ff @(posedge CLK_10MHZ) begin
    if (!RESET && WR_EN && ({1'b0, WR_ADDR} < (AW+1)'(PIXELS))) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  // Line level for the cycle after the coming edge, from the bit and tick that will be current then.
  always_comb begin
    tick_last = (tick == TW'(BIT_TICKS - 1));
    bit_last  = (bitn == BW'(DW - 1));
    pix_last  = (pix == AW'(PIXELS - 1));
    nxt_bit   = 1'b0;
    nxt_tick  = '0;
    unique case (state)
      S_LOAD: nxt_bit = mem[0][DW-1];
      S_BIT: begin
        if (!tick_last) begin
          nxt_bit  = shift[DW-1];
          nxt_tick = tick + TW'(1);
        end else if (!bit_last) begin
          nxt_bit = shift[DW-2];
        end else begin
          nxt_bit = pre[DW-1];
        end
      end
      default: nxt_bit = 1'b0;
    endcase
    neo_nxt = (nxt_tick < (nxt_bit ? TW'(T1H_TICKS) : TW'(T0H_TICKS)));
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (RESET) begin
      state    <= S_IDLE;
      NEO_DATA <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      tick     <= '0;
      bitn     <= '0;
      pix      <= '0;
      lat      <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          NEO_DATA <= 1'b0;
          if (START || LOOP) begin
            state <= S_LOAD;
            BUSY  <= 1'b1;
          end
        end
        S_LOAD: begin
          shift    <= mem[0];
          tick     <= '0;
          bitn     <= '0;
          pix      <= '0;
          NEO_DATA <= neo_nxt;
          state    <= S_BIT;
        end
        S_BIT: begin
          NEO_DATA <= neo_nxt;
          if (!tick_last) begin
            tick <= tick + TW'(1);
          end else begin
            tick <= '0;
            if (!bit_last) begin
              bitn  <= bitn + BW'(1);
              shift <= {shift[DW-2:0], 1'b0};
              // Fetch the next pixel as the last bit of this one starts.
              if ((bitn == BW'(DW - 2)) && !pix_last) begin
                pre <= mem[pix + AW'(1)];
              end
            end else if (!pix_last) begin
              bitn  <= '0;
              pix   <= pix + AW'(1);
              shift <= pre;
            end else begin
              bitn     <= '0;
              pix      <= '0;
              lat      <= '0;
              NEO_DATA <= 1'b0;
              state    <= S_LATCH;
            end
          end
        end
        S_LATCH: begin
          NEO_DATA <= 1'b0;
          if (lat == RW'(RESET_TICKS - 1)) begin
            lat  <= '0;
            DONE <= 1'b1;
            if (LOOP) begin
              state <= S_LOAD;
            end else begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            lat <= lat + RW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anton_neopixel_buffered.sv
// Scoreboard bench: a frame-timing model predicts pixel words, start cycles and DONE
// cycles; a monitor decodes the serial line and compares against the queues.
module tb_anton_neopixel_buffered;

  localparam int unsigned P       = 2;
  localparam int unsigned BPP     = 3;
  localparam int unsigned BT      = 12;
  localparam int unsigned T0H     = 3;
  localparam int unsigned T1H     = 8;
  localparam int unsigned RT      = 500;
  localparam int unsigned NB      = 8 * BPP;
  localparam int unsigned PIX_CYC = NB * BT;
  localparam int unsigned FRAME   = 1 + P * PIX_CYC + RT;
  localparam int unsigned AW      = (P > 1) ? $clog2(P) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_data;
  logic          start;
  logic          loop_en;
  logic          busy;
  logic          done;
  logic          neo;
  logic [1:0]    vstate;

  anton_neopixel_buffered #(
    .PIXELS(P), .BYTES_PER_PIXEL(BPP), .BIT_TICKS(BT),
    .T0H_TICKS(T0H), .T1H_TICKS(T1H), .RESET_TICKS(RT)
  ) dut (
    .CLK_10MHZ(clk), .RESET(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .START(start), .LOOP(loop_en), .BUSY(busy), .DONE(done), .NEO_DATA(neo),
    .VERBOSE_STATE(vstate)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] word;
    logic [31:0]   start;
  } px_t;

  px_t           pix_q[$];
  int unsigned   done_q[$];
  logic [NB-1:0] mem_m [P];
  int unsigned   cyc = 0;
  int unsigned   m_load = 0;
  bit            m_busy = 1'b0;
  bit            exp_busy = 1'b0;
  int unsigned   exp_state = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: frame occupies 1 load cycle, P*NB*BT bit cycles, RT latch cycles.
  // Pixel 0 is read at the end of load; pixel p>0 as the last bit of pixel p-1 starts.
  always @(posedge clk) begin
    int unsigned rel;
    px_t         item;
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      pix_q.delete();
      done_q.delete();
    end else begin
      if (m_busy) begin
        rel = cyc - m_load;
        if (rel == 1) begin
          item.word  = mem_m[0];
          item.start = cyc;
          pix_q.push_back(item);
        end
        for (int p = 1; p < P; p++) begin
          if (rel == 1 + p * PIX_CYC - BT) begin
            item.word  = mem_m[p];
            item.start = cyc + BT;
            pix_q.push_back(item);
          end
        end
        if (rel == FRAME) begin
          done_q.push_back(cyc);
          if (loop_en) m_load = cyc;
          else m_busy = 1'b0;
        end
      end else if (start || loop_en) begin
        m_busy = 1'b1;
        m_load = cyc;
      end
      if (wr_en && (int'(wr_addr) < P)) mem_m[wr_addr] = wr_data;
    end
    rel      = cyc - m_load;
    exp_busy = m_busy;
    if (!m_busy)                exp_state = 0;
    else if (rel == 0)          exp_state = 1;
    else if (rel <= P * PIX_CYC) exp_state = 2;
    else                        exp_state = 3;
  end

  // Monitor: decodes the serial line into words and checks control outputs each cycle.
  bit            in_word = 1'b0;
  bit            have_exp;
  bit            lowseen;
  bit            bad;
  int unsigned   tick_m;
  int unsigned   bitn_m;
  int unsigned   hi;
  logic [NB-1:0] word_m;
  px_t           cur;

  always @(posedge clk) begin
    bit exp_d;
    #1;
    chk("busy", busy, exp_busy);
    chk("state", vstate, exp_state);
    exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
    chk("done", done, exp_d);
    if (exp_d) void'(done_q.pop_front());
    if (rst) begin
      chk("reset_neo", neo, 0);
      in_word = 1'b0;
    end else begin
      if (!in_word && neo) begin
        have_exp = (pix_q.size() > 0);
        if (have_exp) begin
          cur = pix_q.pop_front();
          chk("pixel_start", cyc, cur.start);
        end else begin
          chk("unexpected_pulse", neo, 0);
        end
        in_word = 1'b1;
        tick_m  = 0;
        bitn_m  = 0;
        hi      = 0;
        lowseen = 1'b0;
        bad     = 1'b0;
        word_m  = '0;
      end
      if (in_word) begin
        if (neo) begin
          if (lowseen) bad = 1'b1;
          hi++;
        end else begin
          lowseen = 1'b1;
        end
        if (tick_m == BT - 1) begin
          chk("bit_contiguous", bad, 0);
          if (have_exp) chk("bit_high_ticks", hi, cur.word[NB-1-bitn_m] ? T1H : T0H);
          word_m  = {word_m[NB-2:0], (hi == T1H)};
          bitn_m++;
          tick_m  = 0;
          hi      = 0;
          lowseen = 1'b0;
          bad     = 1'b0;
          if (bitn_m == NB) begin
            if (have_exp) chk("pixel_word", word_m, cur.word);
            in_word = 1'b0;
          end
        end else begin
          tick_m++;
        end
      end
    end
  end

  task automatic write(input int unsigned addr, input logic [NB-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame with the reference pattern.
    write(0, 24'hFF00D5);
    write(1, 24'h000001);
    pulse_start();
    wait_idle(FRAME + 20);

    // Reset during bit 10 of pixel 0, colliding with START and a write.
    pulse_start();
    repeat (125) @(negedge clk);
    rst = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 24'h123456;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_idle(FRAME + 20);

    // START repeated while busy plus a write to pixel 1 during pixel 0.
    pulse_start();
    for (int i = 1; i <= int'(FRAME) + 3; i++) begin
      start   = (i == 10) || (i == 200) || (i == 600) || (i == 1000) || (i == int'(FRAME));
      wr_en   = (i == 50);
      wr_addr = AW'(1);
      wr_data = 24'hA5A5A5;
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0;
    wait_idle(FRAME + 20);

    // Write to pixel 1 on its prefetch edge: old value goes out.
    pulse_start();
    repeat (1 + PIX_CYC - BT - 1) @(negedge clk);
    write(1, 24'h5A5A5A);
    wait_idle(FRAME + 20);

    // Looping frames, LOOP dropped mid-frame.
    loop_en = 1'b1;
    repeat (2 * FRAME + 300) @(negedge clk);
    loop_en = 1'b0;
    wait_idle(FRAME + 20);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 199) == 0);
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_addr = AW'($urandom);
      wr_data = NB'($urandom);
      if ($urandom_range(0, 1499) == 0) loop_en = ~loop_en;
      rst     = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0; loop_en = 1'b0; rst = 1'b0;
    wait_idle(2 * FRAME + 20);

    chk("pixels_outstanding", pix_q.size(), 0);
    chk("done_outstanding", done_q.size(), 0);
    chk("word_in_flight", in_word, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 40000);
    $display("FAIL watchdog cycle=%0d limit reached", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
